// File: rtl/pong_pkg.sv
// Shared match-controller definitions: state encoding and default timing,
// also used by the display mux.
package pong_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        PLAY  = 2'd2,
        OVER  = 2'd3
    } state_e;

    localparam int SERVE_DELAY_DEF = 2000;
    localparam int RAMP_TICKS_DEF  = 4000;
    localparam int SPEED_INIT_DEF  = 4;
    localparam int SPEED_W         = 5;

    function automatic logic signed [SPEED_W-1:0] speed_inc(
        input logic signed [SPEED_W-1:0] s,
        input logic signed [SPEED_W-1:0] smax
    );
        return (s >= smax) ? s : s + 5'sd1;
    endfunction

endpackage

// File: rtl/btn_pulse.sv
// Two-flop synchroniser for an asynchronous button, followed by a rising-edge
// detector whose one-cycle pulse is registered.
module btn_pulse (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic pulse_o
);

    // [0],[1] synchroniser stages, [2] previous synchronised level
    logic [2:0] sync_q;
    logic       pulse_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[1:0], btn_i};
            pulse_q <= sync_q[1] & ~sync_q[2];
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/game_ctrl.sv
// Match controller: keeps both scores, sequences serve/play/game-over and
// drives the ball engine's reset and speed, ramping speed during long rallies.
module game_ctrl
    import pong_pkg::*;
#(
    parameter int SCORE_W     = 4,
    parameter int WIN_SCORE   = 9,
    parameter int SERVE_DELAY = SERVE_DELAY_DEF,
    parameter int RAMP_TICKS  = RAMP_TICKS_DEF,
    parameter int SPEED_INIT  = SPEED_INIT_DEF,
    parameter int SPEED_MAX   = 15
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic                      out_left,
    input  logic                      out_right,
    output logic                      ball_reset,
    output logic signed [SPEED_W-1:0] speed,
    output logic [SCORE_W-1:0]        score_l,
    output logic [SCORE_W-1:0]        score_r,
    output logic                      game_over,
    output logic                      winner
);

    localparam int SRV_W = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
    localparam int RMP_W = (RAMP_TICKS > 1) ? $clog2(RAMP_TICKS) : 1;
    localparam logic [SRV_W-1:0]          SRV_LAST = SRV_W'(SERVE_DELAY - 1);
    localparam logic [RMP_W-1:0]          RMP_LAST = RMP_W'(RAMP_TICKS - 1);
    localparam logic signed [SPEED_W-1:0] SPD_INIT = SPEED_W'(SPEED_INIT);
    localparam logic signed [SPEED_W-1:0] SPD_MAX  = SPEED_W'(SPEED_MAX);
    localparam logic [SCORE_W-1:0]        WIN      = SCORE_W'(WIN_SCORE);

    state_e                    state_q;
    logic [SRV_W-1:0]          srv_cnt_q;
    logic [RMP_W-1:0]          rmp_cnt_q;
    logic signed [SPEED_W-1:0] speed_q;
    logic [SCORE_W-1:0]        score_l_q, score_r_q;
    logic [SCORE_W-1:0]        score_l_d, score_r_d;
    logic                      ball_reset_q, game_over_q, winner_q;
    logic [1:0]                out_l_q, out_r_q;
    logic                      start_pulse;
    logic                      evt_l, evt_r, hit_l, hit_r, win_hit;

    btn_pulse u_start (
        .clk    (clk),
        .rst_n  (reset_n),
        .btn_i  (start),
        .pulse_o(start_pulse)
    );

    // [0] sampled level, [1] previous sample
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_l_q <= '0;
            out_r_q <= '0;
        end else begin
            out_l_q <= {out_l_q[0], out_left};
            out_r_q <= {out_r_q[0], out_right};
        end
    end

    assign evt_l = out_l_q[0] & ~out_l_q[1];
    assign evt_r = out_r_q[0] & ~out_r_q[1];
    // A ball off the left edge is a point for the right player; a tie scores nothing.
    assign hit_l     = evt_l & ~evt_r;
    assign hit_r     = evt_r & ~evt_l;
    assign score_r_d = score_r_q + 1'b1;
    assign score_l_d = score_l_q + 1'b1;
    assign win_hit   = (hit_l && score_r_d == WIN) || (hit_r && score_l_d == WIN);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            srv_cnt_q    <= '0;
            rmp_cnt_q    <= '0;
            speed_q      <= SPD_INIT;
            score_l_q    <= '0;
            score_r_q    <= '0;
            ball_reset_q <= 1'b1;
            game_over_q  <= 1'b0;
            winner_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    ball_reset_q <= 1'b1;
                    if (start_pulse) begin
                        state_q   <= SERVE;
                        srv_cnt_q <= '0;
                        rmp_cnt_q <= '0;
                        speed_q   <= SPD_INIT;
                    end
                end
                SERVE: begin
                    speed_q   <= SPD_INIT;
                    rmp_cnt_q <= '0;
                    if (srv_cnt_q == SRV_LAST) begin
                        srv_cnt_q    <= '0;
                        state_q      <= PLAY;
                        ball_reset_q <= 1'b0;
                    end else begin
                        srv_cnt_q    <= srv_cnt_q + 1'b1;
                        ball_reset_q <= 1'b1;
                    end
                end
                PLAY: begin
                    if (hit_l || hit_r) begin
                        // Scoring takes priority over a coincident ramp tick.
                        ball_reset_q <= 1'b1;
                        srv_cnt_q    <= '0;
                        rmp_cnt_q    <= '0;
                        if (hit_l) score_r_q <= score_r_d;
                        else       score_l_q <= score_l_d;
                        if (win_hit) begin
                            state_q     <= OVER;
                            game_over_q <= 1'b1;
                            winner_q    <= hit_l;
                        end else begin
                            state_q <= SERVE;
                            speed_q <= SPD_INIT;
                        end
                    end else begin
                        ball_reset_q <= 1'b0;
                        if (rmp_cnt_q == RMP_LAST) begin
                            rmp_cnt_q <= '0;
                            speed_q   <= speed_inc(speed_q, SPD_MAX);
                        end else begin
                            rmp_cnt_q <= rmp_cnt_q + 1'b1;
                        end
                    end
                end
                OVER: begin
                    ball_reset_q <= 1'b1;
                    if (start_pulse) begin
                        score_l_q   <= '0;
                        score_r_q   <= '0;
                        game_over_q <= 1'b0;
                        state_q     <= SERVE;
                        srv_cnt_q   <= '0;
                        speed_q     <= SPD_INIT;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ball_reset = ball_reset_q;
    assign speed      = speed_q;
    assign score_l    = score_l_q;
    assign score_r    = score_r_q;
    assign game_over  = game_over_q;
    assign winner     = winner_q;

endmodule
